alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/alu_core.sv | 123 ++++++++++++
 rtl/alu_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer: datapath widths,
// opcode encoding, FSM states and status-register bit positions.
package alu_pkg;

  localparam int ALU_WIDTH = 20;
  localparam int ALU_HALF  = 10;

  // sr = {S, Z, C}
  localparam int SR_C = 0;
  localparam int SR_Z = 1;
  localparam int SR_S = 2;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_TRAP  = 5'd1,
    OP_JMP   = 5'd2,
    OP_JZ    = 5'd3,
    OP_JS    = 5'd4,
    OP_JZS   = 5'd5,
    OP_LDSR  = 5'd6,
    OP_XORSR = 5'd7,
    OP_NOT   = 5'd8,
    OP_AND   = 5'd9,
    OP_OR    = 5'd10,
    OP_XOR   = 5'd11,
    OP_SHR   = 5'd12,
    OP_SHL   = 5'd13,
    OP_ROR   = 5'd14,
    OP_ROL   = 5'd15,
    OP_SWP   = 5'd16,
    OP_INC   = 5'd17,
    OP_DEC   = 5'd18,
    OP_ADD   = 5'd19,
    OP_ADC   = 5'd20,
    OP_SUB   = 5'd21,
    OP_SBC   = 5'd22,
    OP_EQ    = 5'd23,
    OP_GT    = 5'd24,
    OP_LT    = 5'd25,
    OP_GE    = 5'd26,
    OP_LE    = 5'd27
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE,
    ST_TRAPPED
  } state_t;

  function automatic logic is_shift_op(input logic [4:0] op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
  endfunction

  // Encodings 28-31 are unassigned and behave like TRAP.
  function automatic logic is_trap_op(input logic [4:0] op);
    return (op == OP_TRAP) || (op >= 5'd28);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-step ALU: one operation (shifts by one position),
// half/full-word masking and the resulting status flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int HALF  = ALU_HALF
) (
  input  logic [4:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sr_in,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_b,
  output logic             branch,
  output logic [2:0]       sr_out
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};

  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] am;
  logic [WIDTH-1:0] bm;
  logic [WIDTH-1:0] r;
  logic [IW-1:0]    msb;
  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;
  logic [WIDTH:0]   ext_c;
  logic [WIDTH:0]   arith;
  logic             carry;
  logic             set_sz;
  logic             set_c;
  logic             c_new;

  always_comb begin
    mask  = mode ? {WIDTH{1'b1}} : HALF_MASK;
    msb   = mode ? IW'(WIDTH-1) : IW'(HALF-1);
    am    = a & mask;
    bm    = b & mask;
    ext_a = {1'b0, am};
    ext_b = {1'b0, bm};
    ext_c = {{WIDTH{1'b0}}, sr_in[SR_C]};

    // Operands are masked, so a borrow shows up as a set bit just above the MSB.
    case (op)
      OP_ADD:  arith = ext_a + ext_b;
      OP_ADC:  arith = ext_a + ext_b + ext_c;
      OP_SUB:  arith = ext_a - ext_b;
      OP_SBC:  arith = ext_a - ext_b - ext_c;
      OP_INC:  arith = ext_a + {{WIDTH{1'b0}}, 1'b1};
      OP_DEC:  arith = ext_a - {{WIDTH{1'b0}}, 1'b1};
      default: arith = '0;
    endcase
    carry = mode ? arith[WIDTH] : arith[HALF];

    r      = '0;
    res_b  = '0;
    branch = 1'b0;
    sr_out = sr_in;
    set_sz = 1'b0;
    set_c  = 1'b0;
    c_new  = 1'b0;

    case (op)
      OP_JMP:   begin r = bm; branch = 1'b1; end
      OP_JZ:    begin r = bm; branch = sr_in[SR_Z]; end
      OP_JS:    begin r = bm; branch = sr_in[SR_S]; end
      OP_JZS:   begin r = bm; branch = sr_in[SR_Z] | sr_in[SR_S]; end
      OP_LDSR:  sr_out = a[2:0];
      OP_XORSR: sr_out = sr_in ^ a[2:0];
      OP_NOT:   begin r = ~am;     set_sz = 1'b1; end
      OP_AND:   begin r = am & bm; set_sz = 1'b1; end
      OP_OR:    begin r = am | bm; set_sz = 1'b1; end
      OP_XOR:   begin r = am ^ bm; set_sz = 1'b1; end
      OP_SHR: begin
        r      = am << 1;
        c_new  = am[msb];
        set_sz = 1'b1;
        set_c  = 1'b1;
      end
      OP_SHL: begin
        r      = am >> 1;
        c_new  = am[0];
        set_sz = 1'b1;
        set_c  = 1'b1;
      end
      OP_ROR: begin
        r      = am << 1;
        r[0]   = am[msb];
        set_sz = 1'b1;
      end
      OP_ROL: begin
        r      = am >> 1;
        r[msb] = am[0];
        set_sz = 1'b1;
      end
      OP_SWP:   begin r = bm; res_b = am; end
      OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        r      = arith[WIDTH-1:0];
        c_new  = carry;
        set_sz = 1'b1;
        set_c  = 1'b1;
      end
      OP_EQ:    begin r = am; sr_out[SR_Z] = (am == bm); sr_out[SR_S] = (am < bm); end
      OP_GT:    begin r = am; sr_out[SR_Z] = (am > bm);  sr_out[SR_S] = (am < bm); end
      OP_LT:    begin r = am; sr_out[SR_Z] = (am < bm);  sr_out[SR_S] = (am < bm); end
      OP_GE:    begin r = am; sr_out[SR_Z] = (am >= bm); sr_out[SR_S] = (am < bm); end
      OP_LE:    begin r = am; sr_out[SR_Z] = (am <= bm); sr_out[SR_S] = (am < bm); end
      default:  ;
    endcase

    r = r & mask;
    if (set_sz) begin
      sr_out[SR_S] = r[msb];
      sr_out[SR_Z] = (r == '0);
    end
    if (set_c) sr_out[SR_C] = c_new;
    res = r;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer around alu_core: valid/ready handshakes, multi-cycle
// shifts (one position per cycle), status register and sticky trap.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | ready for an instruction
//   ST_SHIFT   | shifting/rotating one bit per cycle, count > 0
//   ST_DONE    | result held until the consumer takes it
//   ST_TRAPPED | illegal/trap opcode seen, frozen until reset
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int HALF  = ALU_HALF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [WIDTH-1:0] out_res_b,
  output logic             out_branch,
  output logic [2:0]       sr,
  output logic             trap
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_load;
  logic [4:0]       op_q;
  logic             mode_q;
  logic             accept;
  logic             in_shift;
  logic             in_trap;
  logic             last_step;

  logic [4:0]       core_op;
  logic             core_mode;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_res;
  logic [WIDTH-1:0] core_res_b;
  logic             core_branch;
  logic [2:0]       core_sr;

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign trap       = (state == ST_TRAPPED);
  assign accept     = in_valid & in_ready;
  assign in_shift   = is_shift_op(in_op);
  assign in_trap    = is_trap_op(in_op);
  assign last_step  = (count <= CW'(1));
  assign count_load = (32'(in_b[4:0]) >= WIDTH) ? CW'(WIDTH) : CW'(in_b[4:0]);

  // While shifting, the core steps the held working value (kept in out_res).
  always_comb begin
    if (state == ST_SHIFT) begin
      core_op   = op_q;
      core_mode = mode_q;
      core_a    = out_res;
      core_b    = '0;
    end else begin
      core_op   = in_op;
      core_mode = in_mode;
      core_a    = in_a;
      core_b    = in_b;
    end
  end

  alu_core #(
    .WIDTH (WIDTH),
    .HALF  (HALF)
  ) u_core (
    .op     (core_op),
    .mode   (core_mode),
    .a      (core_a),
    .b      (core_b),
    .sr_in  (sr),
    .res    (core_res),
    .res_b  (core_res_b),
    .branch (core_branch),
    .sr_out (core_sr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (in_trap)                             state_nxt = ST_TRAPPED;
          else if (in_shift && count_load != '0)   state_nxt = ST_SHIFT;
          else                                     state_nxt = ST_DONE;
        end
      end
      ST_SHIFT:   if (last_step) state_nxt = ST_DONE;
      ST_DONE:    if (out_ready) state_nxt = ST_IDLE;
      ST_TRAPPED: state_nxt = ST_TRAPPED;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // sr is only committed on the final shift step, so rotates keep C and an
  // aborted shift leaves no partial flag update behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      op_q       <= '0;
      mode_q     <= 1'b0;
      out_res    <= '0;
      out_res_b  <= '0;
      out_branch <= 1'b0;
      sr         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !in_trap) begin
            op_q   <= in_op;
            mode_q <= in_mode;
            if (in_shift) begin
              count      <= count_load;
              out_res    <= in_mode ? in_a : (in_a & HALF_MASK);
              out_res_b  <= '0;
              out_branch <= 1'b0;
            end else begin
              count      <= '0;
              out_res    <= core_res;
              out_res_b  <= core_res_b;
              out_branch <= core_branch;
              sr         <= core_sr;
            end
          end
        end
        ST_SHIFT: begin
          out_res <= core_res;
          count   <= count - CW'(1);
          if (last_step) sr <= core_sr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table through an in-order
// scoreboard, plus backpressure, reset-mid-shift and trap sequences.
module tb_alu_sequencer;

  localparam int W = 20;

  localparam logic [4:0] K_NOP = 5'd0,  K_TRAP = 5'd1,  K_JMP = 5'd2,  K_JZ = 5'd3;
  localparam logic [4:0] K_JS  = 5'd4,  K_JZS  = 5'd5,  K_LDSR = 5'd6, K_XORSR = 5'd7;
  localparam logic [4:0] K_NOT = 5'd8,  K_AND  = 5'd9,  K_OR  = 5'd10, K_XOR = 5'd11;
  localparam logic [4:0] K_SHR = 5'd12, K_SHL  = 5'd13, K_ROR = 5'd14, K_ROL = 5'd15;
  localparam logic [4:0] K_SWP = 5'd16, K_INC  = 5'd17, K_DEC = 5'd18, K_ADD = 5'd19;
  localparam logic [4:0] K_ADC = 5'd20, K_SUB  = 5'd21, K_SBC = 5'd22, K_EQ  = 5'd23;
  localparam logic [4:0] K_GT  = 5'd24, K_LT   = 5'd25, K_GE  = 5'd26, K_LE  = 5'd27;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_op;
  logic         in_mode;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic [W-1:0] out_res_b;
  logic         out_branch;
  logic [2:0]   sr;
  logic         trap;

  typedef struct packed {
    logic [4:0]   op;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] res_b;
    logic         br;
    logic [2:0]   sr;
    logic [5:0]   lat;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  alu_sequencer #(.WIDTH(W), .HALF(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_mode    (in_mode),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_res_b  (out_res_b),
    .out_branch (out_branch),
    .sr         (sr),
    .trap       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic [4:0] op, input logic mode, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic [W-1:0] res_b,
                       input logic br, input logic [2:0] s, input int lat);
    vec_t v;
    v.op = op; v.mode = mode; v.a = a; v.b = b; v.res = res; v.res_b = res_b;
    v.br = br; v.sr = s; v.lat = 6'(lat);
    vecs.push_back(v);
  endtask

  // Issue one instruction, wait for its result, compare against the
  // scoreboard head, optionally hold out_ready low, then retire.
  task automatic run_op(input int idx, input vec_t v, input int hold);
    int   waits;
    logic busy_ok;
    vec_t e;
    chk($sformatf("v%0d in_ready_idle", idx), 32'(in_ready), 1);
    in_op = v.op; in_mode = v.mode; in_a = v.a; in_b = v.b; in_valid = 1'b1;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);
    in_op = 5'(($urandom % 28));
    waits = 0;
    busy_ok = 1'b1;
    while (!out_valid && waits < 64) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      waits++;
    end
    if (!out_valid) begin
      chk($sformatf("v%0d out_valid_timeout", idx), 32'(out_valid), 1);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("v%0d latency", idx), 32'(waits), 32'(e.lat));
    chk($sformatf("v%0d in_ready_busy", idx), 32'(busy_ok), 1);
    chk($sformatf("v%0d out_res", idx), 32'(out_res), 32'(e.res));
    chk($sformatf("v%0d out_res_b", idx), 32'(out_res_b), 32'(e.res_b));
    chk($sformatf("v%0d out_branch", idx), 32'(out_branch), 32'(e.br));
    chk($sformatf("v%0d sr", idx), 32'(sr), 32'(e.sr));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("v%0d hold%0d out_valid", idx, h), 32'(out_valid), 1);
      chk($sformatf("v%0d hold%0d out_res", idx, h), 32'(out_res), 32'(e.res));
      chk($sformatf("v%0d hold%0d in_ready", idx, h), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d retire out_valid", idx), 32'(out_valid), 0);
    chk($sformatf("v%0d retire in_ready", idx), 32'(in_ready), 1);
  endtask

  task automatic quick(input int idx, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic [2:0] s,
                       input int hold);
    vec_t v;
    v.op = op; v.mode = 1'b1; v.a = a; v.b = b; v.res = res; v.res_b = '0;
    v.br = 1'b0; v.sr = s; v.lat = 6'd0;
    run_op(idx, v, hold);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_mode = 1'b1;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    chk("reset sr", 32'(sr), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_res", 32'(out_res), 0);
    chk("reset out_res_b", 32'(out_res_b), 0);
    chk("reset out_branch", 32'(out_branch), 0);
    chk("reset trap", 32'(trap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 32'(in_ready), 1);

    //      op       mode  a          b          res        res_b      br  sr      lat
    add_v(K_ADD,   1, 20'hFFFFF, 20'h00001, 20'h00000, 20'h0,     0, 3'b011, 0);
    add_v(K_ADD,   0, 20'hFF3FF, 20'hAB001, 20'h00000, 20'h0,     0, 3'b011, 0);
    add_v(K_LDSR,  1, 20'h00002, 20'h00000, 20'h00000, 20'h0,     0, 3'b010, 0);
    add_v(K_JZ,    1, 20'h00000, 20'h00123, 20'h00123, 20'h0,     1, 3'b010, 0);
    add_v(K_JS,    1, 20'h00000, 20'h00456, 20'h00456, 20'h0,     0, 3'b010, 0);
    add_v(K_JMP,   1, 20'h00000, 20'hABCDE, 20'hABCDE, 20'h0,     1, 3'b010, 0);
    add_v(K_XORSR, 1, 20'h00005, 20'h00000, 20'h00000, 20'h0,     0, 3'b111, 0);
    add_v(K_JZS,   1, 20'h00000, 20'h00007, 20'h00007, 20'h0,     1, 3'b111, 0);
    add_v(K_SUB,   1, 20'h00005, 20'h00007, 20'hFFFFE, 20'h0,     0, 3'b101, 0);
    add_v(K_SBC,   1, 20'h0000A, 20'h00003, 20'h00006, 20'h0,     0, 3'b000, 0);
    add_v(K_ADC,   1, 20'h7FFFF, 20'h80000, 20'hFFFFF, 20'h0,     0, 3'b100, 0);
    add_v(K_INC,   1, 20'hFFFFF, 20'h00000, 20'h00000, 20'h0,     0, 3'b011, 0);
    add_v(K_ADC,   1, 20'h00001, 20'h00002, 20'h00004, 20'h0,     0, 3'b000, 0);
    add_v(K_DEC,   1, 20'h00000, 20'h00000, 20'hFFFFF, 20'h0,     0, 3'b101, 0);
    add_v(K_AND,   1, 20'hF0F0F, 20'h0FF00, 20'h00F00, 20'h0,     0, 3'b001, 0);
    add_v(K_OR,    0, 20'h00200, 20'h00100, 20'h00300, 20'h0,     0, 3'b101, 0);
    add_v(K_XOR,   1, 20'h12345, 20'h12345, 20'h00000, 20'h0,     0, 3'b011, 0);
    add_v(K_NOT,   1, 20'h0000F, 20'h00000, 20'hFFFF0, 20'h0,     0, 3'b101, 0);
    add_v(K_NOT,   0, 20'h0000F, 20'h00000, 20'h003F0, 20'h0,     0, 3'b101, 0);
    add_v(K_SWP,   1, 20'h11111, 20'h22222, 20'h22222, 20'h11111, 0, 3'b101, 0);
    add_v(K_EQ,    1, 20'h00005, 20'h00005, 20'h00005, 20'h0,     0, 3'b011, 0);
    add_v(K_GT,    1, 20'h00003, 20'h00009, 20'h00003, 20'h0,     0, 3'b101, 0);
    add_v(K_GT,    1, 20'h00009, 20'h00003, 20'h00009, 20'h0,     0, 3'b011, 0);
    add_v(K_LT,    1, 20'h00003, 20'h00009, 20'h00003, 20'h0,     0, 3'b111, 0);
    add_v(K_LT,    0, 20'h00401, 20'h00002, 20'h00001, 20'h0,     0, 3'b111, 0);
    add_v(K_GE,    1, 20'h00009, 20'h00009, 20'h00009, 20'h0,     0, 3'b011, 0);
    add_v(K_LE,    1, 20'h000A0, 20'h0009F, 20'h000A0, 20'h0,     0, 3'b001, 0);
    add_v(K_SUB,   0, 20'h00005, 20'h00007, 20'h003FE, 20'h0,     0, 3'b101, 0);
    add_v(K_NOP,   1, 20'h00001, 20'h00002, 20'h00000, 20'h0,     0, 3'b101, 0);
    add_v(K_LDSR,  1, 20'h00000, 20'h00000, 20'h00000, 20'h0,     0, 3'b000, 0);
    add_v(K_SHL,   1, 20'h00001, 20'h00003, 20'h00000, 20'h0,     0, 3'b010, 3);
    add_v(K_SHR,   1, 20'h80001, 20'h00001, 20'h00002, 20'h0,     0, 3'b001, 1);
    add_v(K_ROR,   1, 20'h80001, 20'h00002, 20'h00006, 20'h0,     0, 3'b001, 2);
    add_v(K_ROL,   0, 20'h00001, 20'h00001, 20'h00200, 20'h0,     0, 3'b101, 1);
    add_v(K_SHR,   1, 20'h12345, 20'h00000, 20'h12345, 20'h0,     0, 3'b101, 0);
    add_v(K_SHL,   1, 20'hFFFFF, 20'h0001F, 20'h00000, 20'h0,     0, 3'b011, 20);
    add_v(K_ROL,   1, 20'h12345, 20'h00019, 20'h12345, 20'h0,     0, 3'b001, 20);
    add_v(K_SHL,   0, 20'hFFC03, 20'h00002, 20'h00000, 20'h0,     0, 3'b011, 2);

    foreach (vecs[i]) run_op(i, vecs[i], 0);

    // Consumer stalls five cycles in DONE.
    quick(100, K_ADD, 20'h00001, 20'h00002, 20'h00003, 3'b000, 5);

    // Reset asserted while a 10-step shift is in flight.
    quick(101, K_LDSR, 20'h00007, 20'h00000, 20'h00000, 3'b111, 0);
    in_op = K_SHR; in_mode = 1'b1; in_a = 20'h00001; in_b = 20'h0000A; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midshift out_valid", 32'(out_valid), 0);
    chk("midshift in_ready", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset sr", 32'(sr), 0);
    chk("async reset out_res", 32'(out_res), 0);
    chk("async reset in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after abort in_ready", 32'(in_ready), 1);
    chk("after abort sr", 32'(sr), 0);
    repeat (12) @(negedge clk);
    chk("after abort out_valid", 32'(out_valid), 0);
    quick(102, K_ADD, 20'h00002, 20'h00002, 20'h00004, 3'b000, 0);

    // Unassigned opcode 30 traps; further requests are ignored.
    quick(103, K_LDSR, 20'h00005, 20'h00000, 20'h00000, 3'b101, 0);
    in_op = 5'd30; in_a = 20'h00001; in_b = 20'h00001; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("trap30 trap", 32'(trap), 1);
    chk("trap30 in_ready", 32'(in_ready), 0);
    chk("trap30 out_valid", 32'(out_valid), 0);
    in_op = K_ADD;
    repeat (4) @(negedge clk);
    chk("trap30 sticky trap", 32'(trap), 1);
    chk("trap30 sticky out_valid", 32'(out_valid), 0);
    chk("trap30 sticky in_ready", 32'(in_ready), 0);
    chk("trap30 sr unchanged", 32'(sr), 32'(3'b101));
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("trap cleared by reset", 32'(trap), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("trap reset in_ready", 32'(in_ready), 1);

    // Explicit TRAP opcode.
    in_op = K_TRAP; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("trap1 trap", 32'(trap), 1);
    chk("trap1 in_ready", 32'(in_ready), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
